// File: rtl/spr_pkg.sv
// spr_pkg: shared constants and types for the gamma re-encoding search.
// Holds the 33-entry breakpoint table (linear-domain segment starts), the
// search FSM state type and the field widths of the output code.
package spr_pkg;

  localparam int SEG_W  = 5;
  localparam int FRAC_W = 3;
  localparam int LIN_W  = 12;

  localparam int TBL_LAST = 32;

  // Segment k covers [BOUND_T[k], BOUND_T[k+1]); the final entry is the
  // saturation threshold.
  localparam logic [LIN_W-1:0] BOUND_T [0:TBL_LAST] = '{
    12'd0,    12'd4,    12'd8,    12'd12,   12'd16,   12'd20,   12'd24,
    12'd28,   12'd32,   12'd36,   12'd40,   12'd44,   12'd46,   12'd57,
    12'd67,   12'd90,   12'd118,  12'd151,  12'd187,  12'd228,  12'd273,
    12'd322,  12'd376,  12'd434,  12'd565,  12'd714,  12'd883,  12'd1071,
    12'd1280, 12'd1509, 12'd1759, 12'd2029, 12'd2065
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRCH = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } spr_state_e;

endpackage

// File: rtl/spr_re_gamma_bound_rom.sv
// spr_re_gamma_bound_rom: combinational breakpoint lookup.
// Ports:
//   idx_i  6-bit table index (0..32 valid; larger indices return the last entry)
//   val_o  12-bit breakpoint value
module spr_re_gamma_bound_rom
  import spr_pkg::*;
(
  input  logic [5:0]       idx_i,
  output logic [LIN_W-1:0] val_o
);

  always_comb begin
    val_o = BOUND_T[TBL_LAST];
    if (idx_i <= 6'(TBL_LAST)) begin
      val_o = BOUND_T[idx_i];
    end
  end

endmodule

// File: rtl/spr_re_gamma_search.sv
// spr_re_gamma_search: converts a 12-bit linear sample into an 8-bit
// gamma-domain code {seg[4:0], frac[2:0]} by a 5-step binary search over the
// breakpoint table followed by a short restoring division for the fraction.
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   sample present on in_lin
//   in_ready   idle, a sample is accepted on the next edge with in_valid
//   in_lin     12-bit unsigned linear sample
//   out_valid  out_code holds a result
//   out_ready  downstream takes out_code
//   out_code   8-bit gamma code
// Build option:
//   SPR_REGAMMA_ROUND_EN  computes one extra fraction bit and rounds
//                         half-up (saturating at 0xFF); adds one cycle.
module spr_re_gamma_search
  import spr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LIN_W-1:0] in_lin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code
);

`ifdef SPR_REGAMMA_ROUND_EN
  localparam int FSTEPS = FRAC_W + 1;
`else
  localparam int FSTEPS = FRAC_W;
`endif
  localparam logic [2:0] STEP_LAST = 3'(FSTEPS - 1);

  spr_state_e        state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [7:0]        out_code_q;
  logic [SEG_W-1:0]  seg_q;
  logic [LIN_W-1:0]  tseg_q;       // T[seg_q], tracked as the search keeps bits
  logic [LIN_W-1:0]  v_q;
  logic              sat_q;
  logic [2:0]        bit_q;
  logic [2:0]        step_q;
  logic [12:0]       rem_q;
  logic [FSTEPS-2:0] frac_q;       // fraction bits collected so far

  logic [SEG_W-1:0]  cand_seg;
  logic [LIN_W-1:0]  t_cand;
  logic [5:0]        seg_hi_idx;
  logic [LIN_W-1:0]  t_hi;
  logic [LIN_W-1:0]  d_w;
  logic [12:0]       rem_cur;
  logic [13:0]       rem_sh;
  logic              rem_ge;
  logic [12:0]       rem_d;
  logic [FSTEPS-1:0] frac_d;
  logic [7:0]        code_d;
`ifdef SPR_REGAMMA_ROUND_EN
  logic [9:0]        code_rnd;
`endif

  assign cand_seg   = seg_q | (SEG_W'(1) << bit_q);
  assign seg_hi_idx = {1'b0, seg_q} + 6'd1;

  spr_re_gamma_bound_rom u_rom_cand (
    .idx_i ({1'b0, cand_seg}),
    .val_o (t_cand)
  );

  // Upper bound of the chosen segment; the lower bound is already in tseg_q.
  spr_re_gamma_bound_rom u_rom_hi (
    .idx_i (seg_hi_idx),
    .val_o (t_hi)
  );

  always_comb begin
    d_w     = t_hi - tseg_q;
    // The first division step starts from v - T[seg] directly.
    rem_cur = (step_q == 3'd0) ? {1'b0, v_q - tseg_q} : rem_q;
    rem_sh  = {rem_cur, 1'b0};
    rem_ge  = (rem_sh >= {2'b00, d_w});
    rem_d   = rem_ge ? 13'(rem_sh - {2'b00, d_w}) : rem_sh[12:0];
    frac_d  = {frac_q, rem_ge};
`ifdef SPR_REGAMMA_ROUND_EN
    code_rnd = ({1'b0, seg_q, frac_d} + 10'd1) >> 1;
    code_d   = (code_rnd > 10'd255) ? 8'hFF : code_rnd[7:0];
`else
    code_d   = {seg_q, frac_d};
`endif
    if (sat_q) begin
      code_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= 8'h00;
      seg_q       <= '0;
      tseg_q      <= '0;
      v_q         <= '0;
      sat_q       <= 1'b0;
      bit_q       <= '0;
      step_q      <= '0;
      rem_q       <= '0;
      frac_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= SRCH;
            in_ready_q <= 1'b0;
            v_q        <= in_lin;
            sat_q      <= (in_lin >= BOUND_T[TBL_LAST]);
            seg_q      <= '0;
            tseg_q     <= BOUND_T[0];
            bit_q      <= 3'(SEG_W - 1);
            step_q     <= '0;
            rem_q      <= '0;
            frac_q     <= '0;
          end
        end
        SRCH: begin
          if (t_cand <= v_q) begin
            seg_q  <= cand_seg;
            tseg_q <= t_cand;
          end
          if (bit_q == 3'd0) begin
            state_q <= FRAC;
            step_q  <= '0;
          end else begin
            bit_q <= bit_q - 3'd1;
          end
        end
        FRAC: begin
          rem_q  <= rem_d;
          frac_q <= frac_d[FSTEPS-2:0];
          step_q <= step_q + 3'd1;
          if (step_q == STEP_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_code_q  <= code_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;

endmodule

// File: tb/tb_spr_re_gamma_search.sv
module tb_spr_re_gamma_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_lin;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_code;

  int checks   = 0;
  int failures = 0;

`ifdef SPR_REGAMMA_ROUND_EN
  localparam int LAT = 9;
  localparam logic [7:0] EXP_50   = 8'h63;
  localparam logic [7:0] EXP_1000 = 8'hD5;
`else
  localparam int LAT = 8;
  localparam logic [7:0] EXP_50   = 8'h62;
  localparam logic [7:0] EXP_1000 = 8'hD4;
`endif

  int unsigned tbl [0:32] = '{
    0, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 46, 57, 67, 90, 118, 151,
    187, 228, 273, 322, 376, 434, 565, 714, 883, 1071, 1280, 1509, 1759,
    2029, 2065
  };

  spr_re_gamma_search dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lin    (in_lin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_code(input int unsigned v);
    int unsigned seg, r, d, c;
    if (v >= 2065) return 8'hFF;
    seg = 0;
    for (int k = 0; k < 32; k++) if (tbl[k] <= v) seg = k;
    r = v - tbl[seg];
    d = tbl[seg + 1] - tbl[seg];
`ifdef SPR_REGAMMA_ROUND_EN
    c = (seg * 16 + (16 * r) / d + 1) / 2;
    if (c > 255) c = 255;
`else
    c = seg * 8 + (8 * r) / d;
`endif
    return 8'(c);
  endfunction

  // Called and returning at #1 after a rising edge.
  task automatic run_one(input string tag, input logic [11:0] v, input int hold,
                         input logic [7:0] exp);
    int n;
    in_valid = 1'b1;
    in_lin   = v;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_accept"}, in_ready, 1);
    @(posedge clk); #1;               // transfer edge
    in_valid = 1'b0;
    in_lin   = 12'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_code"}, out_code, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_code"}, out_code, exp);
      chk({tag, "_hold_vld"}, out_valid, 1);
      chk({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rel_vld"}, out_valid, 0);
    chk({tag, "_rel_rdy"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_lin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 8'h00);

    run_one("v0",    12'd0,    0, 8'h00);
    run_one("v4",    12'd4,    0, 8'h08);
    run_one("v118",  12'd118,  1, 8'h80);
    run_one("v6",    12'd6,    0, 8'h0C);
    run_one("v50",   12'd50,   0, EXP_50);
    run_one("v44",   12'd44,   0, 8'h58);
    run_one("v45",   12'd45,   0, 8'h5C);
    run_one("v2029", 12'd2029, 0, 8'hF8);
    run_one("v2064", 12'd2064, 0, 8'hFF);
    run_one("v2065", 12'd2065, 0, 8'hFF);
    run_one("v4095", 12'd4095, 0, 8'hFF);
    run_one("v1000", 12'd1000, 20, EXP_1000);

    // Reset in the third search cycle discards the sample and held result.
    in_valid = 1'b1; in_lin = 12'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_code", out_code, 8'h00);
    run_one("post_rst", 12'd118, 0, 8'h80);

    for (int v = 0; v < 4096; v++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_one("sweep", 12'(v), $urandom_range(0, 2), ref_code(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
